// File: rtl/fb_pkg.sv
// fb_pkg
//   Shared constants and helpers for the framebuffer write path.
//   - VGA visible-area constants used as default bounds.
//   - Pixel record layout {hpos, vpos, rgb}, packed MSB to LSB, with field offsets.
//   - Legality check for the write FIFO depth.
package fb_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_V_DISPLAY = 480;

    // Width of one stored pixel record.
    function automatic int rec_width(input int xw, input int yw, input int cw);
        return xw + yw + cw;
    endfunction

    // Field offsets inside a record.
    function automatic int rgb_lsb();
        return 0;
    endfunction

    function automatic int vpos_lsb(input int cw);
        return cw;
    endfunction

    function automatic int hpos_lsb(input int yw, input int cw);
        return yw + cw;
    endfunction

    // The FIFO pointers wrap by natural overflow, so the depth must be a power of two.
    function automatic bit depth_is_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fb_write_scheduler_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter with a rotating priority pointer.
//   Ports:
//     clk, reset_n : clock and asynchronous active-low reset
//     req          : per-requester request vector
//     advance      : the current grant completed, so move priority past it
//     grant        : one-hot grant (all zero when nothing is requested)
//   Search starts at ptr; after a completed grant, ptr moves to the granted index + 1.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;

    // The loop walks from the farthest offset down to offset 0.
    // The last hit therefore belongs to the requester closest to ptr.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
//   Merges NUM_SRC pixel producers into one framebuffer write port.
//   - Producers are arbitrated round-robin into a DEPTH-entry register FIFO.
//   - The FIFO drains only during blanking, on pixel-enable cycles.
//   Ports:
//     clk, reset_n            : pixel clock, asynchronous active-low reset
//     display_on, enable      : scan-out active flag and pixel-clock enable
//     src_valid/src_ready     : per-source handshake
//     src_hpos/src_vpos/src_rgb : packed beats; source i uses slice [i*W +: W]
//     fb_we, fb_hpos, fb_vpos, fb_rgb : framebuffer write port
//     fb_own                  : scheduler owns the framebuffer address mux
//     level, empty, full      : FIFO occupancy
//     overflow_cnt            : saturating count of beats dropped while full
//   Handshake: a beat moves on a rising edge where src_valid[i] and src_ready[i] are both high.
//   src_ready is combinational from src_valid, so a source must not wait for ready before raising valid.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int X_WIDTH      = 10,
    parameter int Y_WIDTH      = 10,
    parameter int COLOR_WIDTH  = 3,
    parameter int DEPTH        = 16,
    parameter int H_DISPLAY    = VGA_H_DISPLAY,
    parameter int V_DISPLAY    = VGA_V_DISPLAY,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           display_on,
    input  logic                           enable,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*X_WIDTH-1:0]     src_hpos,
    input  logic [NUM_SRC*Y_WIDTH-1:0]     src_vpos,
    input  logic [NUM_SRC*COLOR_WIDTH-1:0] src_rgb,
    output logic                           fb_we,
    output logic [X_WIDTH-1:0]             fb_hpos,
    output logic [Y_WIDTH-1:0]             fb_vpos,
    output logic [COLOR_WIDTH-1:0]         fb_rgb,
    output logic                           fb_own,
    output logic [$clog2(DEPTH):0]         level,
    output logic                           empty,
    output logic                           full,
    output logic [15:0]                    overflow_cnt
);

    localparam int REC_W = rec_width(X_WIDTH, Y_WIDTH, COLOR_WIDTH);
    localparam int H_LSB = hpos_lsb(Y_WIDTH, COLOR_WIDTH);
    localparam int V_LSB = vpos_lsb(COLOR_WIDTH);
    localparam int C_LSB = rgb_lsb();
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;

    // One extra bit so a bound equal to 2**X_WIDTH still compares correctly.
    localparam logic [X_WIDTH:0] H_LIM = (X_WIDTH + 1)'(H_DISPLAY);
    localparam logic [Y_WIDTH:0] V_LIM = (Y_WIDTH + 1)'(V_DISPLAY);

    if (!depth_is_legal(DEPTH)) begin : g_bad_depth
        $error("fb_write_scheduler: DEPTH must be a power of two >= 2");
    end
    if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
        $error("fb_write_scheduler: NUM_SRC must be in 1..8");
    end

    logic [NUM_SRC-1:0]     req;
    logic [NUM_SRC-1:0]     grant;
    logic                   can_accept;
    logic                   xfer;
    logic                   in_bounds;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic [X_WIDTH-1:0]     sel_hpos;
    logic [Y_WIDTH-1:0]     sel_vpos;
    logic [COLOR_WIDTH-1:0] sel_rgb;
    logic [REC_W-1:0]       mem [DEPTH];
    logic [REC_W-1:0]       head;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    // In drop mode a full FIFO still grants, so the beat is consumed and counted.
    // Holding reset also holds every grant low.
    assign can_accept = !full || DROP_ON_FULL;
    assign req        = (reset_n && can_accept) ? src_valid : '0;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (xfer),
        .grant   (grant)
    );

    assign src_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        sel_hpos = '0;
        sel_vpos = '0;
        sel_rgb  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_hpos = src_hpos[i*X_WIDTH +: X_WIDTH];
                sel_vpos = src_vpos[i*Y_WIDTH +: Y_WIDTH];
                sel_rgb  = src_rgb[i*COLOR_WIDTH +: COLOR_WIDTH];
            end
        end
    end

    // Off-screen beats are consumed silently; they never count as overflow.
    assign in_bounds = ({1'b0, sel_hpos} < H_LIM) && ({1'b0, sel_vpos} < V_LIM);
    assign push      = xfer && in_bounds && !full;
    assign drop      = xfer && in_bounds && full;
    assign pop       = !display_on && enable && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    // Storage is not reset; entries become visible only through level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sel_hpos, sel_vpos, sel_rgb};
        end
    end

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign head  = mem[rd_ptr];

    assign fb_we   = pop;
    assign fb_own  = ~display_on;
    assign fb_hpos = empty ? '0 : head[H_LSB +: X_WIDTH];
    assign fb_vpos = empty ? '0 : head[V_LSB +: Y_WIDTH];
    assign fb_rgb  = empty ? '0 : head[C_LSB +: COLOR_WIDTH];

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler
//   Two schedulers share one stimulus stream:
//     dut 0 back-pressures when full; dut 1 drops beats when full.
//   A queue-based reference model predicts the contents of each FIFO.
//   A negedge monitor checks outputs against the model and pops expected writes.
module tb_fb_write_scheduler;

    localparam int NS  = 3;
    localparam int XW  = 10;
    localparam int YW  = 10;
    localparam int CW  = 3;
    localparam int DEP = 8;
    localparam int LVW = $clog2(DEP) + 1;
    localparam int RW  = XW + YW + CW;
    localparam int NI  = 2;

    // ---------------- clock / reset / stimulus signals ----------------
    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic             display_on = 1'b0;
    logic             enable     = 1'b0;
    logic [NS-1:0]    src_valid  = '0;
    logic [NS*XW-1:0] src_hpos   = '0;
    logic [NS*YW-1:0] src_vpos   = '0;
    logic [NS*CW-1:0] src_rgb    = '0;

    logic [NS-1:0]  src_ready_o [NI];
    logic           fb_we_o     [NI];
    logic [XW-1:0]  fb_hpos_o   [NI];
    logic [YW-1:0]  fb_vpos_o   [NI];
    logic [CW-1:0]  fb_rgb_o    [NI];
    logic           fb_own_o    [NI];
    logic [LVW-1:0] level_o     [NI];
    logic           empty_o     [NI];
    logic           full_o      [NI];
    logic [15:0]    ovf_o       [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fb_write_scheduler #(
            .NUM_SRC      (NS),
            .X_WIDTH      (XW),
            .Y_WIDTH      (YW),
            .COLOR_WIDTH  (CW),
            .DEPTH        (DEP),
            .H_DISPLAY    (640),
            .V_DISPLAY    (480),
            .DROP_ON_FULL (g == 1)
        ) dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .display_on   (display_on),
            .enable       (enable),
            .src_valid    (src_valid),
            .src_ready    (src_ready_o[g]),
            .src_hpos     (src_hpos),
            .src_vpos     (src_vpos),
            .src_rgb      (src_rgb),
            .fb_we        (fb_we_o[g]),
            .fb_hpos      (fb_hpos_o[g]),
            .fb_vpos      (fb_vpos_o[g]),
            .fb_rgb       (fb_rgb_o[g]),
            .fb_own       (fb_own_o[g]),
            .level        (level_o[g]),
            .empty        (empty_o[g]),
            .full         (full_o[g]),
            .overflow_cnt (ovf_o[g])
        );
    end

    // ---------------- reference model / scoreboard state ----------------
    logic [RW-1:0] mdl_q [NI][$];   // predicted FIFO contents
    logic [RW-1:0] exp_q [NI][$];   // expected framebuffer writes, in order
    int            rr_start [NI];
    int            ovf_mdl  [NI];
    int            wr_cnt   [NI];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // First valid source at or after start, or -1 if none is valid or the scheduler refuses.
    function automatic int pick(input logic [NS-1:0] v, input int start, input bit blocked);
        int i;
        if (blocked) return -1;
        for (int k = 0; k < NS; k++) begin
            i = (start + k) % NS;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [RW-1:0] beat(input int i);
        return {src_hpos[i*XW +: XW], src_vpos[i*YW +: YW], src_rgb[i*CW +: CW]};
    endfunction

    function automatic bit on_screen(input logic [RW-1:0] r);
        return (int'(r[RW-1 -: XW]) < 640) && (int'(r[CW +: YW]) < 480);
    endfunction

    // Model: one step per clock edge, using the inputs that were stable before the edge.
    int            m_gi;
    bit            m_full;
    bit            m_pop;
    logic [RW-1:0] m_rec;
    logic [RW-1:0] m_tmp;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int g = 0; g < NI; g++) begin
                mdl_q[g].delete();
                exp_q[g].delete();
                rr_start[g] = 0;
                ovf_mdl[g]  = 0;
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                m_full = (mdl_q[g].size() == DEP);
                m_pop  = !display_on && enable && (mdl_q[g].size() != 0);
                m_gi   = pick(src_valid, rr_start[g], m_full && (g == 0));
                if (m_pop) m_tmp = mdl_q[g].pop_front();
                if (m_gi >= 0) begin
                    rr_start[g] = (m_gi + 1) % NS;
                    m_rec = beat(m_gi);
                    if (on_screen(m_rec)) begin
                        if (!m_full) begin
                            mdl_q[g].push_back(m_rec);
                            exp_q[g].push_back(m_rec);
                        end else if (ovf_mdl[g] < 65535) begin
                            ovf_mdl[g]++;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compare mid-cycle and consume expected writes whenever a DUT writes.
    int            n_sz;
    int            n_gi;
    logic [31:0]   n_rdy;
    logic [RW-1:0] n_head;
    logic [RW-1:0] n_act;
    logic [RW-1:0] n_exp;

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            n_sz  = mdl_q[g].size();
            n_gi  = pick(src_valid, rr_start[g], (g == 0) && (n_sz == DEP));
            n_rdy = (reset_n && n_gi >= 0) ? (32'd1 << n_gi) : 32'd0;
            chk("src_ready", g, 32'(src_ready_o[g]), n_rdy);
            chk("level", g, 32'(level_o[g]), 32'(n_sz));
            chk("empty", g, 32'(empty_o[g]), 32'(n_sz == 0));
            chk("full", g, 32'(full_o[g]), 32'(n_sz == DEP));
            chk("overflow_cnt", g, 32'(ovf_o[g]), 32'(ovf_mdl[g]));
            chk("fb_own", g, 32'(fb_own_o[g]), 32'(!display_on));
            chk("fb_we", g, 32'(fb_we_o[g]), 32'(!display_on && enable && n_sz != 0));
            n_head = (n_sz != 0) ? mdl_q[g][0] : '0;
            n_act  = {fb_hpos_o[g], fb_vpos_o[g], fb_rgb_o[g]};
            chk("head", g, 32'(n_act), 32'(n_head));
            if (fb_we_o[g]) begin
                if (exp_q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write dut%0d: got write 0x%0h expected no write at %0t", g, n_act, $time);
                end else begin
                    n_exp = exp_q[g].pop_front();
                    chk("write", g, 32'(n_act), 32'(n_exp));
                    wr_cnt[g]++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input bit v, input int h, input int y, input int c);
        src_valid[i]           = v;
        src_hpos[i*XW +: XW]   = XW'(h);
        src_vpos[i*YW +: YW]   = YW'(y);
        src_rgb[i*CW +: CW]    = CW'(c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base_wr [NI];

    initial begin
        // ---------------- reset ----------------
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        for (int g = 0; g < NI; g++) begin
            chk("reset level", g, 32'(level_o[g]), 32'd0);
            chk("reset empty", g, 32'(empty_o[g]), 32'd1);
            chk("reset full", g, 32'(full_o[g]), 32'd0);
            chk("reset overflow", g, 32'(ovf_o[g]), 32'd0);
            chk("reset fb_we", g, 32'(fb_we_o[g]), 32'd0);
        end

        // ---------------- three beats held during active video, then drained ----------------
        display_on = 1'b1;
        enable     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_src(0, 1'b1, 100 + k, 50 + k, k + 1);
            tick(1);
        end
        src_valid = '0;
        tick(1);
        for (int g = 0; g < NI; g++) begin
            chk("held level", g, 32'(level_o[g]), 32'd3);
            chk("held fb_we", g, 32'(fb_we_o[g]), 32'd0);
            base_wr[g] = wr_cnt[g];
        end
        display_on = 1'b0;
        tick(3);
        for (int g = 0; g < NI; g++) begin
            chk("drain writes", g, 32'(wr_cnt[g] - base_wr[g]), 32'd3);
            chk("drain level", g, 32'(level_o[g]), 32'd0);
        end

        // ---------------- all sources valid: rotation, fill, back-pressure / drop ----------------
        // Source 0 was granted last, so the rotation resumes at source 1.
        display_on = 1'b1;
        for (int k = 0; k < 13; k++) begin
            for (int i = 0; i < NS; i++) begin
                set_src(i, 1'b1, $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 7));
            end
            #2;
            chk("rotation bp", 0, 32'(src_ready_o[0]), (k < DEP) ? (32'd1 << ((k + 1) % 3)) : 32'd0);
            chk("rotation drop", 1, 32'(src_ready_o[1]), 32'd1 << ((k + 1) % 3));
            tick(1);
        end
        src_valid = '0;
        tick(1);
        chk("fill level", 0, 32'(level_o[0]), 32'(DEP));
        chk("fill level", 1, 32'(level_o[1]), 32'(DEP));
        chk("fill full", 0, 32'(full_o[0]), 32'd1);
        chk("fill overflow", 0, 32'(ovf_o[0]), 32'd0);
        chk("fill overflow", 1, 32'(ovf_o[1]), 32'd5);
        display_on = 1'b0;
        tick(DEP + 1);
        for (int g = 0; g < NI; g++) chk("fill drained", g, 32'(level_o[g]), 32'd0);

        // ---------------- off-screen beats are consumed, not stored ----------------
        display_on = 1'b1;
        set_src(1, 1'b1, 640, 10, 5);
        #2;
        for (int g = 0; g < NI; g++) chk("oob x ready", g, 32'(src_ready_o[g]), 32'b010);
        tick(1);
        set_src(1, 1'b1, 5, 480, 6);
        #2;
        for (int g = 0; g < NI; g++) chk("oob y ready", g, 32'(src_ready_o[g]), 32'b010);
        tick(1);
        src_valid = '0;
        tick(1);
        chk("oob level", 0, 32'(level_o[0]), 32'd0);
        chk("oob level", 1, 32'(level_o[1]), 32'd0);
        chk("oob overflow", 0, 32'(ovf_o[0]), 32'd0);
        chk("oob overflow", 1, 32'(ovf_o[1]), 32'd5);

        // ---------------- blanking with enable every other clock, pushes continuing ----------------
        display_on = 1'b0;
        for (int k = 0; k < 20; k++) begin
            enable = k[0];
            for (int i = 0; i < NS; i++) begin
                set_src(i, 1'($urandom_range(0, 1)), $urandom_range(0, 639), $urandom_range(0, 479),
                        $urandom_range(0, 7));
            end
            tick(1);
        end
        src_valid = '0;
        enable    = 1'b1;
        tick(DEP + 2);

        // ---------------- asynchronous reset mid-stream ----------------
        display_on = 1'b1;
        for (int k = 0; k < 7; k++) begin
            set_src(2, 1'b1, 200 + k, 300 + k, k);
            tick(1);
        end
        src_valid = '0;
        tick(1);
        for (int g = 0; g < NI; g++) chk("pre-reset level", g, 32'(level_o[g]), 32'd7);
        set_src(2, 1'b1, 33, 44, 7);
        reset_n = 1'b0;
        #2;
        for (int g = 0; g < NI; g++) begin
            chk("async level", g, 32'(level_o[g]), 32'd0);
            chk("async empty", g, 32'(empty_o[g]), 32'd1);
            chk("async overflow", g, 32'(ovf_o[g]), 32'd0);
            chk("async ready", g, 32'(src_ready_o[g]), 32'd0);
            chk("async fb_hpos", g, 32'(fb_hpos_o[g]), 32'd0);
        end
        tick(2);
        reset_n = 1'b1;
        tick(1);
        src_valid = '0;
        #2;
        for (int g = 0; g < NI; g++) begin
            chk("post-reset level", g, 32'(level_o[g]), 32'd1);
            chk("post-reset hpos", g, 32'(fb_hpos_o[g]), 32'd33);
            chk("post-reset vpos", g, 32'(fb_vpos_o[g]), 32'd44);
            chk("post-reset rgb", g, 32'(fb_rgb_o[g]), 32'd7);
        end
        tick(1);

        // ---------------- randomized traffic ----------------
        for (int k = 0; k < 400; k++) begin
            display_on = ((k % 60) < 30) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
            enable     = 1'($urandom_range(0, 1));
            for (int i = 0; i < NS; i++) begin
                set_src(i, 1'($urandom_range(0, 1)), $urandom_range(0, 700), $urandom_range(0, 520),
                        $urandom_range(0, 7));
            end
            tick(1);
        end
        src_valid  = '0;
        display_on = 1'b0;
        enable     = 1'b1;
        tick(DEP + 4);
        for (int g = 0; g < NI; g++) begin
            chk("final level", g, 32'(level_o[g]), 32'd0);
            chk("final pending writes", g, 32'(exp_q[g].size()), 32'd0);
        end

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
